// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, flush vector, exception codes and stage metadata type
package pipe_pkg;

  localparam int          PC_W_DEF     = 32;
  localparam int          EXC_W_DEF    = 5;
  localparam logic [31:0] FLUSH_PC_DEF = 32'h0000_4180;

  typedef enum logic [EXC_W_DEF-1:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic [PC_W_DEF-1:0]  pc;
    logic                 bd;
    logic [EXC_W_DEF-1:0] exc;
  } stage_meta_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream handshake bundle of one pipeline stage register
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic              in_bd;
  logic [EXC_W-1:0]  in_exc;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;
  logic              out_bd;
  logic [EXC_W-1:0]  out_exc;

  // master: the side producing instructions and consuming the registered output
  modport master (
    output in_valid, in_data, in_pc, in_bd, in_exc, out_ready,
    input  in_ready, out_valid, out_data, out_pc, out_bd, out_exc
  );

  modport slave (
    input  in_valid, in_data, in_pc, in_bd, in_exc, out_ready,
    output in_ready, out_valid, out_data, out_pc, out_bd, out_exc
  );

endinterface

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one register slot (valid, payload, pc, bd, exc) with load/clear/flush controls
module pipe_slot #(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter int              EXC_W    = 5,
  parameter logic [PC_W-1:0] FLUSH_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              clear,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_data,
  input  logic [PC_W-1:0]   d_pc,
  input  logic              d_bd,
  input  logic [EXC_W-1:0]  d_exc,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [PC_W-1:0]   q_pc,
  output logic              q_bd,
  output logic [EXC_W-1:0]  q_exc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_pc    <= '0;
      q_bd    <= 1'b0;
      q_exc   <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_pc    <= FLUSH_PC;
      q_bd    <= 1'b0;
      q_exc   <= '0;
    end else if (load) begin
      q_valid <= d_valid;
      // a bubble still carries the PC so EPC stays meaningful downstream
      q_pc    <= d_pc;
      q_data  <= d_valid ? d_data : '0;
      q_bd    <= d_valid ? d_bd : 1'b0;
      q_exc   <= d_valid ? d_exc : '0;
    end else if (clear) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register; PIPE_SKID_BUF_EN adds a skid slot and registered in_ready
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = PC_W_DEF,
  parameter int              EXC_W    = EXC_W_DEF,
  parameter logic [PC_W-1:0] FLUSH_PC = PC_W'(FLUSH_PC_DEF),
  parameter int              CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [PC_W-1:0]   main_pc;
  logic              main_bd;
  logic [EXC_W-1:0]  main_exc;

  logic              advance;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic [PC_W-1:0]   src_pc;
  logic              src_bd;
  logic [EXC_W-1:0]  src_exc;

  assign advance = !main_valid || bus.out_ready;

`ifdef PIPE_SKID_BUF_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [PC_W-1:0]   skid_pc;
  logic              skid_bd;
  logic [EXC_W-1:0]  skid_exc;

  assign bus.in_ready = !skid_valid;

  // a parked entry always drains before fresh input so order is preserved
  always_comb begin
    src_valid = bus.in_valid;
    src_data  = bus.in_data;
    src_pc    = bus.in_pc;
    src_bd    = bus.in_bd;
    src_exc   = bus.in_exc;
    if (skid_valid) begin
      src_valid = 1'b1;
      src_data  = skid_data;
      src_pc    = skid_pc;
      src_bd    = skid_bd;
      src_exc   = skid_exc;
    end
  end

  pipe_slot #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .EXC_W   (EXC_W),
    .FLUSH_PC(FLUSH_PC)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .load   (!advance && bus.in_valid && !skid_valid),
    .clear  (advance),
    .d_valid(1'b1),
    .d_data (bus.in_data),
    .d_pc   (bus.in_pc),
    .d_bd   (bus.in_bd),
    .d_exc  (bus.in_exc),
    .q_valid(skid_valid),
    .q_data (skid_data),
    .q_pc   (skid_pc),
    .q_bd   (skid_bd),
    .q_exc  (skid_exc)
  );
`else
  assign bus.in_ready = advance;
  assign src_valid    = bus.in_valid;
  assign src_data     = bus.in_data;
  assign src_pc       = bus.in_pc;
  assign src_bd       = bus.in_bd;
  assign src_exc      = bus.in_exc;
`endif

  pipe_slot #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .EXC_W   (EXC_W),
    .FLUSH_PC(FLUSH_PC)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .load   (advance),
    .clear  (1'b0),
    .d_valid(src_valid),
    .d_data (src_data),
    .d_pc   (src_pc),
    .d_bd   (src_bd),
    .d_exc  (src_exc),
    .q_valid(main_valid),
    .q_data (main_data),
    .q_pc   (main_pc),
    .q_bd   (main_bd),
    .q_exc  (main_exc)
  );

  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_pc    = main_pc;
  assign bus.out_bd    = main_bd;
  assign bus.out_exc   = main_exc;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      stall_cnt <= '0;
    end else if (main_valid && !bus.out_ready) begin
      if (stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - vector table plus stream/stall sequences for pipe_stage_reg
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int EW = 5;
  localparam int CW = 8;
  localparam int NV = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .PC_W(PW), .EXC_W(EW)) bus ();

  pipe_stage_reg #(
    .DATA_W  (DW),
    .PC_W    (PW),
    .EXC_W   (EW),
    .FLUSH_PC(32'h0000_4180),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic          rst;
    logic          fl;
    logic          iv;
    logic [31:0]   d;
    logic [31:0]   pc;
    logic          bd;
    logic [EW-1:0] exc;
    logic          ordy;
    logic          ov;
    logic [31:0]   od;
    logic [31:0]   opc;
    logic          obd;
    logic [EW-1:0] oexc;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int rst, input int fl, input int iv, input logic [31:0] d,
                              input logic [31:0] pc, input int bd, input int exc, input int ordy,
                              input int ov, input logic [31:0] od, input logic [31:0] opc,
                              input int obd, input int oexc, input int cnt);
    vec_t v;
    v.rst = (rst != 0);  v.fl = (fl != 0);   v.iv = (iv != 0);
    v.d = d;             v.pc = pc;          v.bd = (bd != 0);
    v.exc = EW'(exc);    v.ordy = (ordy != 0);
    v.ov = (ov != 0);    v.od = od;          v.opc = opc;
    v.obd = (obd != 0);  v.oexc = EW'(oexc); v.cnt = CW'(cnt);
    return v;
  endfunction

  task automatic drive(input logic rst, input logic fl, input logic iv, input logic [31:0] d,
                       input logic [31:0] pc, input logic bd, input logic [EW-1:0] exc, input logic ordy);
    reset         = rst;
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_pc     = pc;
    bus.in_bd     = bd;
    bus.in_exc    = exc;
    bus.out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          idx_in;
    int          idx_out;
    int          cyc;
    logic [15:0] rdy_pat;
    logic        acc;
    logic        oxf;
    logic [31:0] opc;
    logic [31:0] od;

    vecs[0]  = mk(1,0,1,'hD0,'h3000,0,0,1,         0,0,0,0,0,0);
    vecs[1]  = mk(1,0,1,'hD0,'h3000,0,0,1,         0,0,0,0,0,0);
    vecs[2]  = mk(0,0,0,0,0,0,0,1,                 0,0,0,0,0,0);
    vecs[3]  = mk(0,0,1,'h11,'h3000,0,0,1,         1,'h11,'h3000,0,0,0);
    vecs[4]  = mk(0,0,1,'h22,'h3004,1,0,1,         1,'h22,'h3004,1,0,0);
    for (int k = 0; k < 5; k++)
      vecs[5+k] = mk(0,0,0,'hEE,'h3100,0,0,0,      1,'h22,'h3004,1,0,k+1);
    vecs[10] = mk(0,0,1,'h33,'h3008,0,0,1,         1,'h33,'h3008,0,0,0);
    vecs[11] = mk(0,1,1,'h44,'h300C,0,EXC_OV,1,    0,0,'h4180,0,0,0);
    vecs[12] = mk(0,0,0,'hEE,'h3010,1,3,1,         0,0,'h3010,0,0,0);
    vecs[13] = mk(0,0,1,'h55,'h3014,1,EXC_OV,1,    1,'h55,'h3014,1,12,0);
    vecs[14] = mk(0,0,0,0,0,0,0,0,                 1,'h55,'h3014,1,12,1);
    vecs[15] = mk(0,1,0,0,0,0,0,0,                 0,0,'h4180,0,0,0);
    vecs[16] = mk(0,0,1,'h66,'h3018,0,0,0,         1,'h66,'h3018,0,0,0);
    vecs[17] = mk(0,0,0,0,0,0,0,0,                 1,'h66,'h3018,0,0,1);
    vecs[18] = mk(1,0,0,0,0,0,0,0,                 0,0,0,0,0,0);
    vecs[19] = mk(0,0,1,'h77,'h301C,0,EXC_ADEL,1,  1,'h77,'h301C,0,4,0);
    vecs[20] = mk(0,0,0,'hEE,'h3020,0,0,1,         0,0,'h3020,0,0,0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].pc,
            vecs[i].bd, vecs[i].exc, vecs[i].ordy);
      step();
      check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
      check($sformatf("v%0d_out_data", i),  bus.out_data,        vecs[i].od);
      check($sformatf("v%0d_out_pc", i),    bus.out_pc,          vecs[i].opc);
      check($sformatf("v%0d_out_bd", i),    32'(bus.out_bd),     32'(vecs[i].obd));
      check($sformatf("v%0d_out_exc", i),   32'(bus.out_exc),    32'(vecs[i].oexc));
      check($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt),      32'(vecs[i].cnt));
    end

    // streaming with out_ready gaps: every PC must appear once, in order
    drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, '0, 1'b1);
    step();
    idx_in  = 0;
    idx_out = 0;
    cyc     = 0;
    rdy_pat = 16'b1111_1111_0011_0111;
    while (idx_out < 8 && cyc < 40) begin
      drive(1'b0, 1'b0, idx_in < 8, 32'hD000 + 32'(idx_in), 32'h5000 + 32'(4 * idx_in),
            1'b0, '0, (cyc < 16) ? rdy_pat[cyc] : 1'b1);
      #1;
`ifdef PIPE_SKID_BUF_EN
      if (cyc == 3) check("skid_in_ready_on_drop", 32'(bus.in_ready), 32'd1);
`endif
      acc = bus.in_valid && bus.in_ready;
      oxf = bus.out_valid && bus.out_ready;
      opc = bus.out_pc;
      od  = bus.out_data;
      step();
      if (acc) idx_in++;
      if (oxf) begin
        check($sformatf("stream_pc_%0d", idx_out),   opc, 32'h5000 + 32'(4 * idx_out));
        check($sformatf("stream_data_%0d", idx_out), od,  32'hD000 + 32'(idx_out));
        idx_out++;
      end
      cyc++;
    end
    check("stream_transfer_count", 32'(idx_out), 32'd8);

    // in_ready while stalled, then stall counter saturation
    drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, '0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'h99, 32'h6000, 1'b0, '0, 1'b0);
    step();
    check("sat_loaded_valid", 32'(bus.out_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 0, 32'h6004, 1'b0, '0, 1'b0);
    #1;
`ifdef PIPE_SKID_BUF_EN
    check("in_ready_stalled", 32'(bus.in_ready), 32'd1);
`else
    check("in_ready_stalled", 32'(bus.in_ready), 32'd0);
`endif
    bus.out_ready = 1'b1;
    #1;
    check("in_ready_out_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    repeat (260) step();
    check("stall_cnt_saturated", 32'(stall_cnt), 32'd255);
    check("sat_hold_pc", bus.out_pc, 32'h6000);
    bus.out_ready = 1'b1;
    step();
    check("stall_cnt_clear_on_xfer", 32'(stall_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register carrying payload, PC, delay-slot flag and exception code between any two adjacent stages (F→D, D→E, E→M, M→W). It replaces the per-stage hand-written registers with one block that has a valid/ready handshake, a flush that injects the exception-vector PC, a bubble valid bit and a saturating stall counter. An optional skid entry breaks the combinational ready path.

## Interface
Parameters:
- DATA_W, 32, payload width (instruction word plus any stage-specific fields)
- PC_W, 32, PC width
- EXC_W, 5, exception-code width
- FLUSH_PC, 32'h0000_4180, PC loaded on flush (handler entry)
- CNT_W, 8, stall-counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  interrupt/exception flush, active-high
- in_valid  in  1  upstream holds a real instruction
- in_ready  out  1  block accepts this cycle
- in_data  in  DATA_W  payload
- in_pc  in  PC_W  PC
- in_bd  in  1  delay-slot flag
- in_exc  in  EXC_W  exception code (0 = none)
- out_valid  out  1  output holds a real instruction
- out_ready  in  1  downstream accepts this cycle
- out_data / out_pc / out_bd / out_exc  out  DATA_W / PC_W / 1 / EXC_W  registered fields
- stall_cnt  out  CNT_W  consecutive cycles out_valid && !out_ready, saturating

## Operation
- Reset: reset reset, synchronous, active-high; clock clk. All outputs 0 (out_pc = 0, out_valid = 0, stall_cnt = 0).
- Priority per edge: reset > flush > advance > hold.
- Flush: out_valid←0, out_data←0, out_bd←0, out_exc←0, out_pc←FLUSH_PC, stall_cnt←0; in_data discarded; skid entry cleared.
- Advance condition: main slot empty or out_ready. On advance:
  - in_valid=1: load all fields, out_valid←1.
  - in_valid=0: bubble; out_valid←0, out_data/out_bd/out_exc←0, out_pc←in_pc (keeps PC tracking for EPC).
- Hold: all fields unchanged.
- in_exc passes through unmodified; the block never creates exceptions.
- stall_cnt: +1 each cycle out_valid && !out_ready, saturates at 2^CNT_W−1, clears on any transfer (out_valid && out_ready) or flush.
- Without skid: in_ready = !out_valid || out_ready (combinational).

## Timing
- Latency 1 cycle in→out at full throughput (one transfer per cycle sustained).
- Transfer occurs on an edge where valid && ready on the respective side.
- Flush and in_valid in the same cycle: flush wins; input lost (upstream flushed too).
- Flush while stalled: stall_cnt clears same edge; out_valid low the next cycle.
- Reset mid-stall: identical to power-on reset.

## Configuration
- PIPE_SKID_BUF_EN defined: one extra skid slot; in_ready = !skid_valid (registered, no path from out_ready). Input accepted while main slot stalled goes to skid; on out_ready, skid moves to main next edge (skid first, order preserved); main fills from input directly when skid empty. Still 1-cycle latency when not stalled, full throughput.
- Undefined: no skid slot; combinational in_ready as above.

## Structure
- Package pipe_pkg: PC_W, EXC_W, FLUSH_PC default, ExcCode constants (Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12), typedef stage_meta_t {pc, bd, exc}.
- Sub-module pipe_slot: one register slot (valid + data + meta) with load/clear/flush-PC controls; instantiated once as main, once more as skid under PIPE_SKID_BUF_EN.

## Test plan
- Reset asserted, in_valid=1 in_pc=0x3000 → all outputs 0 during and one cycle after release.
- Stream in_pc 0x3000,0x3004,0x3008 with out_ready=1 → out_pc same sequence one cycle later, out_valid=1 each cycle.
- out_ready=0 for 5 cycles with out_pc=0x3004 held → out fields constant, stall_cnt 1..5, clears to 0 on transfer.
- flush while in_valid=1 in_exc=12 → next cycle out_valid=0, out_pc=0x4180, out_exc=0.
- in_valid=0, in_pc=0x3010, out_ready=1 → out_valid=0, out_data=0, out_pc=0x3010.
- PIPE_SKID_BUF_EN: out_ready drops one cycle mid-stream → in_ready stays 1 that cycle, no lost/duplicated PCs, order preserved; CNT_W=2 held 6 cycles → stall_cnt saturates at 3.
